// File: rtl/add_norm_round_pkg.sv
// add_norm_round_pkg: widths, mantissa bit positions, constants and FSM encoding
// shared by the FP32 add/normalize/round stage.
package add_norm_round_pkg;
   localparam int MANT_W  = 28;
   localparam int EXP_W   = 8;
   localparam int IEXP_W  = 10;
   localparam int CARRY   = 27;
   localparam int HIDDEN  = 26;
   localparam int LSB     = 3;
   localparam int G_BIT   = 2;
   localparam int R_BIT   = 1;
   localparam int S_BIT   = 0;
   localparam int EXP_MAX = 255;

   localparam logic [31:0] INF_POS = 32'h7F80_0000;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ADD   = 3'd1,
      NORM  = 3'd2,
      ROUND = 3'd3,
      DONE  = 3'd4
   } state_t;
endpackage

// File: rtl/add_norm_round_lzc28.sv
// lzc28: 28-bit leading-zero counter (28 for an all-zero input).
// Only elaborated when FP_NORM_LZC_EN is defined, since only that build uses it.
`ifdef FP_NORM_LZC_EN
module lzc28 (
   input  logic [27:0] val,
   output logic [4:0]  cnt
);
   always_comb begin
      cnt = 5'd28;
      // ascending scan: the highest set bit makes the last assignment
      for (int i = 0; i <= 27; i++) begin
         if (val[i]) cnt = 5'(27 - i);
      end
   end
endmodule
`endif

// File: rtl/add_norm_round.sv
// add_norm_round: FP32 adder back end -- add/subtract aligned mantissas, normalize, round-to-nearest-even, pack.
// FP_NORM_LZC_EN: single-cycle leading-zero normalize; otherwise NORM shifts left one bit per cycle.
//
// state | meaning
// IDLE  | waiting for an operand bundle (in_ready high)
// ADD   | add or subtract the latched mantissas
// NORM  | bring the hidden bit to position 26, or flush/zero
// ROUND | round to nearest-even, detect overflow, pack
// DONE  | result and flags held until out_ready
module add_norm_round
   import add_norm_round_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              sign_of_great,
   input  logic              sign_of_small,
   input  logic [EXP_W-1:0]  exp,
   input  logic [MANT_W-1:0] mantis_great,
   input  logic [MANT_W-1:0] mantis_small,
   input  logic              shift_loss,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       result,
   output logic              overflow,
   output logic              underflow,
   output logic              inexact
);
   state_t                   state_q, state_d;
   logic                     sign_q, sign_d;
   logic                     sign_small_q, sign_small_d;
   logic signed [IEXP_W-1:0] exp_q, exp_d;
   logic [MANT_W-1:0]        great_q, great_d;
   logic [MANT_W-1:0]        small_q, small_d;
   logic [MANT_W-1:0]        sum_q, sum_d;
   logic                     sticky_q, sticky_d;
   logic                     zero_q, zero_d;
   logic                     flush_q, flush_d;
   logic [31:0]              result_q, result_d;
   logic                     overflow_q, overflow_d;
   logic                     underflow_q, underflow_d;
   logic                     inexact_q, inexact_d;

   logic                     g_bit, r_bit, s_bit, rnd_up;
   logic [24:0]              mant_rnd;
   logic signed [IEXP_W-1:0] exp_rnd;
   logic [22:0]              frac_rnd;

`ifdef FP_NORM_LZC_EN
   logic [4:0] lz_cnt;
   logic [4:0] lz_shift;

   lzc28 u_lzc (
      .val (sum_q),
      .cnt (lz_cnt)
   );

   // only used once sum[27:26]==0, so lz_cnt >= 2 here
   assign lz_shift = lz_cnt - 5'd1;
`endif

   assign g_bit    = sum_q[G_BIT];
   assign r_bit    = sum_q[R_BIT];
   assign s_bit    = sum_q[S_BIT] | sticky_q;
   assign rnd_up   = g_bit & (r_bit | s_bit | sum_q[LSB]);
   assign mant_rnd = {1'b0, sum_q[HIDDEN:LSB]} + {24'd0, rnd_up};
   assign exp_rnd  = exp_q + (mant_rnd[24] ? 10'sd1 : 10'sd0);
   assign frac_rnd = mant_rnd[24] ? mant_rnd[23:1] : mant_rnd[22:0];

   always_comb begin
      state_d      = state_q;
      sign_d       = sign_q;
      sign_small_d = sign_small_q;
      exp_d        = exp_q;
      great_d      = great_q;
      small_d      = small_q;
      sum_d        = sum_q;
      sticky_d     = sticky_q;
      zero_d       = zero_q;
      flush_d      = flush_q;
      result_d     = result_q;
      overflow_d   = overflow_q;
      underflow_d  = underflow_q;
      inexact_d    = inexact_q;

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               sign_d       = sign_of_great;
               sign_small_d = sign_of_small;
               exp_d        = {2'b00, exp};
               great_d      = mantis_great;
               small_d      = mantis_small;
               sticky_d     = shift_loss;
               zero_d       = 1'b0;
               flush_d      = 1'b0;
               state_d      = ADD;
            end
         end
         ADD: begin
            sum_d   = (sign_q == sign_small_q) ? (great_q + small_q) : (great_q - small_q);
            state_d = NORM;
         end
         NORM: begin
            if (sum_q == '0) begin
               zero_d  = 1'b1;
               state_d = ROUND;
            end else if (sum_q[CARRY]) begin
               sum_d   = {1'b0, sum_q[CARRY:2], sum_q[1] | sum_q[0]};
               exp_d   = exp_q + 10'sd1;
               state_d = ROUND;
            end else if (sum_q[HIDDEN]) begin
               state_d = ROUND;
            end else begin
`ifdef FP_NORM_LZC_EN
               // a shift beyond exp-1 would leave the hidden bit clear at exp==1: flush
               if ($signed({5'd0, lz_shift}) > (exp_q - 10'sd1)) begin
                  flush_d = 1'b1;
               end else begin
                  sum_d = sum_q << lz_shift;
                  exp_d = exp_q - $signed({5'd0, lz_shift});
               end
               state_d = ROUND;
`else
               if (exp_q <= 10'sd1) begin
                  flush_d = 1'b1;
                  state_d = ROUND;
               end else begin
                  sum_d = {sum_q[MANT_W-2:0], 1'b0};
                  exp_d = exp_q - 10'sd1;
               end
`endif
            end
         end
         ROUND: begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            inexact_d   = 1'b0;
            if (zero_q) begin
               result_d = 32'h0000_0000;
            end else if (flush_q) begin
               result_d    = {sign_q, 31'd0};
               underflow_d = 1'b1;
               inexact_d   = 1'b1;
            end else if (exp_rnd >= $signed(10'(EXP_MAX))) begin
               result_d   = {sign_q, INF_POS[30:0]};
               overflow_d = 1'b1;
               inexact_d  = 1'b1;
            end else begin
               result_d  = {sign_q, exp_rnd[EXP_W-1:0], frac_rnd};
               inexact_d = g_bit | r_bit | s_bit;
            end
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         sign_q       <= 1'b0;
         sign_small_q <= 1'b0;
         exp_q        <= '0;
         great_q      <= '0;
         small_q      <= '0;
         sum_q        <= '0;
         sticky_q     <= 1'b0;
         zero_q       <= 1'b0;
         flush_q      <= 1'b0;
         result_q     <= '0;
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
         inexact_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         sign_q       <= sign_d;
         sign_small_q <= sign_small_d;
         exp_q        <= exp_d;
         great_q      <= great_d;
         small_q      <= small_d;
         sum_q        <= sum_d;
         sticky_q     <= sticky_d;
         zero_q       <= zero_d;
         flush_q      <= flush_d;
         result_q     <= result_d;
         overflow_q   <= overflow_d;
         underflow_q  <= underflow_d;
         inexact_q    <= inexact_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign result    = result_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;
   assign inexact   = inexact_q;
endmodule
